// File: rtl/command_definition_pkg.sv
// rtl/command_definition_pkg.sv - command, violation and state encodings for the DRAM command interface
package command_definition_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } bank_command_t;

    typedef enum logic [3:0] {
        VIOL_NONE        = 4'd0,
        VIOL_BANK_OPEN   = 4'd1,
        VIOL_BANK_CLOSED = 4'd2,
        VIOL_TRP         = 4'd3,
        VIOL_TRCD        = 4'd4,
        VIOL_TCCD        = 4'd5,
        VIOL_TWR         = 4'd6,
        VIOL_BUS         = 4'd7,
        VIOL_BUSY_REF    = 4'd8
    } viol_code_t;

    typedef enum logic {
        BANK_CLOSED = 1'b0,
        BANK_OPEN   = 1'b1
    } bank_state_t;

    typedef enum logic {
        G_READY      = 1'b0,
        G_REFRESHING = 1'b1
    } ref_state_t;

endpackage

// File: rtl/dq_burst_engine.sv
// rtl/dq_burst_engine.sv - CL/CWL delayed burst serialiser/deserialiser with DQ slot reservation
module dq_burst_engine #(
    parameter int DQ_BITS = 16,
    parameter int BL      = 8,
    parameter int CL      = 5,
    parameter int CWL     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rd_start,
    input  logic                  i_wr_start,
    input  logic                  i_query_wr,
    input  logic [BL*DQ_BITS-1:0] i_wr_data,
    output logic                  o_slot_busy,
    output logic [DQ_BITS-1:0]    o_dq_out,
    output logic                  o_dq_oe,
    input  logic [DQ_BITS-1:0]    i_dq_in,
    output logic                  o_read_data_valid,
    output logic [BL*DQ_BITS-1:0] o_full_read_data
);

    localparam int W     = BL * DQ_BITS;
    localparam int SPAN  = ((CL > CWL) ? CL : CWL) + BL;
    localparam int CNT_W = (BL > 2) ? $clog2(BL) : 1;
    localparam int DLY_W = $clog2(CL + CWL + 1);
    localparam logic [SPAN-1:0] RD_MASK = SPAN'(((1 << BL) - 1) << CL);
    localparam logic [SPAN-1:0] WR_MASK = SPAN'(((1 << BL) - 1) << CWL);

    // bit k of busy_q reserves the DQ bus k cycles from now
    logic [SPAN-1:0]  busy_q, busy_d;
    logic             wr_pend_q, wr_act_q, rd_pend_q, rd_act_q, rd_valid_q;
    logic [DLY_W-1:0] wr_dly_q, rd_dly_q;
    logic [CNT_W-1:0] wr_beat_q, rd_beat_q;
    logic [W-1:0]     wr_pend_data_q, wr_sr_q, rd_sr_q, rd_data_q;
    logic [W-1:0]     rd_assembled;

    always_comb begin
        busy_d = busy_q;
        if (i_rd_start) busy_d = busy_d | RD_MASK;
        if (i_wr_start) busy_d = busy_d | WR_MASK;
        busy_d = busy_d >> 1;
        o_slot_busy  = |(busy_q & (i_query_wr ? WR_MASK : RD_MASK));
        rd_assembled = {i_dq_in, rd_sr_q[W-1:DQ_BITS]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q         <= '0;
            wr_pend_q      <= 1'b0;
            wr_act_q       <= 1'b0;
            rd_pend_q      <= 1'b0;
            rd_act_q       <= 1'b0;
            rd_valid_q     <= 1'b0;
            wr_dly_q       <= '0;
            rd_dly_q       <= '0;
            wr_beat_q      <= '0;
            rd_beat_q      <= '0;
            wr_pend_data_q <= '0;
            wr_sr_q        <= '0;
            rd_sr_q        <= '0;
            rd_data_q      <= '0;
        end else begin
            busy_q     <= busy_d;
            rd_valid_q <= 1'b0;

            // pending stage counts down so the burst goes active exactly CWL / CL after the command
            if (i_wr_start) begin
                wr_pend_q      <= 1'b1;
                wr_dly_q       <= DLY_W'(CWL - 2);
                wr_pend_data_q <= i_wr_data;
            end else if (wr_pend_q) begin
                if (wr_dly_q == '0) wr_pend_q <= 1'b0;
                else                wr_dly_q  <= wr_dly_q - 1'b1;
            end
            if (wr_act_q) begin
                wr_sr_q   <= wr_sr_q >> DQ_BITS;
                wr_beat_q <= wr_beat_q + 1'b1;
                if (wr_beat_q == CNT_W'(BL - 1)) wr_act_q <= 1'b0;
            end
            if (wr_pend_q && wr_dly_q == '0) begin
                wr_act_q  <= 1'b1;
                wr_sr_q   <= wr_pend_data_q;
                wr_beat_q <= '0;
            end

            if (i_rd_start) begin
                rd_pend_q <= 1'b1;
                rd_dly_q  <= DLY_W'(CL - 2);
            end else if (rd_pend_q) begin
                if (rd_dly_q == '0) rd_pend_q <= 1'b0;
                else                rd_dly_q  <= rd_dly_q - 1'b1;
            end
            if (rd_act_q) begin
                rd_sr_q   <= rd_assembled;
                rd_beat_q <= rd_beat_q + 1'b1;
                if (rd_beat_q == CNT_W'(BL - 1)) begin
                    rd_act_q   <= 1'b0;
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= rd_assembled;
                end
            end
            if (rd_pend_q && rd_dly_q == '0) begin
                rd_act_q  <= 1'b1;
                rd_beat_q <= '0;
            end
        end
    end

    assign o_dq_oe           = wr_act_q;
    assign o_dq_out          = wr_act_q ? wr_sr_q[DQ_BITS-1:0] : '0;
    assign o_read_data_valid = rd_valid_q;
    assign o_full_read_data  = rd_data_q;

endmodule

// File: rtl/dram_cmd_responder.sv
// rtl/dram_cmd_responder.sv - DRAM command decode, bank table, timing checks and burst data path
module dram_cmd_responder
    import command_definition_pkg::*;
#(
    parameter int DQ_BITS  = 16,
    parameter int BA_BITS  = 3,
    parameter int ROW_BITS = 16,
    parameter int BL       = 8,
    parameter int CL       = 5,
    parameter int CWL      = 4,
    parameter int T_RCD    = 4,
    parameter int T_RP     = 4,
    parameter int T_CCD    = 8,
    parameter int T_WR     = 6,
    parameter int T_RFC    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_cmd_valid,
    input  bank_command_t          i_command,
    input  logic [BA_BITS-1:0]     i_bank_address,
    input  logic [ROW_BITS-1:0]    i_row_address,
    input  logic [BL*DQ_BITS-1:0]  i_full_write_data,
    output logic                   o_cmd_accept,
    output logic                   o_violation,
    output viol_code_t             o_violation_code,
    output logic [DQ_BITS-1:0]     o_dq_out,
    output logic                   o_dq_oe,
    input  logic [DQ_BITS-1:0]     i_dq_in,
    output logic                   o_read_data_valid,
    output logic [BL*DQ_BITS-1:0]  o_full_read_data,
    output logic [2**BA_BITS-1:0]  o_bank_open
);

    localparam int NUM_BANKS = 2 ** BA_BITS;
    localparam int TWR_LOAD  = CWL + BL + T_WR - 1;
    localparam int TMAX      = (T_RFC > TWR_LOAD) ? T_RFC : TWR_LOAD;
    localparam int TMR_W     = $clog2(TMAX + 1);

    // a timer at 1 expires on this edge, so a command in the same cycle already sees it elapsed
    function automatic logic elapsed(input logic [TMR_W-1:0] t);
        return t <= TMR_W'(1);
    endfunction

    function automatic logic [TMR_W-1:0] dec(input logic [TMR_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    bank_state_t         bank_q  [NUM_BANKS];
    logic [ROW_BITS-1:0] row_q   [NUM_BANKS];
    logic [TMR_W-1:0]    trcd_q  [NUM_BANKS];
    logic [TMR_W-1:0]    trp_q   [NUM_BANKS];
    logic [TMR_W-1:0]    twr_q   [NUM_BANKS];
    logic [TMR_W-1:0]    tccd_q, rfc_q;
    ref_state_t          gstate_q, gstate_d;

    logic       is_cmd, cmd_accept, violation, busy_ref, sel_open, any_open, any_trp, slot_busy;
    viol_code_t viol_code;

    always_comb begin
        is_cmd    = 1'b0;
        viol_code = VIOL_NONE;
        any_open  = 1'b0;
        any_trp   = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_q[b] == BANK_OPEN) any_open = 1'b1;
            if (!elapsed(trp_q[b]))     any_trp  = 1'b1;
        end
        sel_open = (bank_q[i_bank_address] == BANK_OPEN);
        busy_ref = (gstate_q == G_REFRESHING) && !elapsed(rfc_q);
        case (i_command)
            CMD_ACT: begin
                is_cmd = 1'b1;
                if (sel_open)                                viol_code = VIOL_BANK_OPEN;
                else if (!elapsed(trp_q[i_bank_address]))    viol_code = VIOL_TRP;
            end
            CMD_RD, CMD_WR: begin
                is_cmd = 1'b1;
                if (!sel_open)                               viol_code = VIOL_BANK_CLOSED;
                else if (!elapsed(trcd_q[i_bank_address]))   viol_code = VIOL_TRCD;
                else if (!elapsed(tccd_q))                   viol_code = VIOL_TCCD;
                else if (slot_busy)                          viol_code = VIOL_BUS;
            end
            CMD_PRE: begin
                is_cmd = 1'b1;
                if (!sel_open)                               viol_code = VIOL_BANK_CLOSED;
                else if (!elapsed(twr_q[i_bank_address]))    viol_code = VIOL_TWR;
            end
            CMD_REF: begin
                is_cmd = 1'b1;
                if (any_open)                                viol_code = VIOL_BANK_OPEN;
                else if (any_trp)                            viol_code = VIOL_TRP;
            end
            default: ;
        endcase
        if (busy_ref)                viol_code = VIOL_BUSY_REF;
        if (!i_cmd_valid || !is_cmd) viol_code = VIOL_NONE;
        violation  = i_cmd_valid && is_cmd && (viol_code != VIOL_NONE);
        cmd_accept = i_cmd_valid && is_cmd && (viol_code == VIOL_NONE);

        gstate_d = gstate_q;
        if (cmd_accept && i_command == CMD_REF)                 gstate_d = G_REFRESHING;
        else if (gstate_q == G_REFRESHING && elapsed(rfc_q))    gstate_d = G_READY;

        for (int b = 0; b < NUM_BANKS; b++) o_bank_open[b] = (bank_q[b] == BANK_OPEN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_q[b] <= BANK_CLOSED;
                row_q[b]  <= '0;
                trcd_q[b] <= '0;
                trp_q[b]  <= '0;
                twr_q[b]  <= '0;
            end
            tccd_q   <= '0;
            rfc_q    <= '0;
            gstate_q <= G_READY;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                trcd_q[b] <= dec(trcd_q[b]);
                trp_q[b]  <= dec(trp_q[b]);
                twr_q[b]  <= dec(twr_q[b]);
            end
            tccd_q   <= dec(tccd_q);
            rfc_q    <= dec(rfc_q);
            gstate_q <= gstate_d;
            if (cmd_accept) begin
                case (i_command)
                    CMD_ACT: begin
                        bank_q[i_bank_address] <= BANK_OPEN;
                        row_q[i_bank_address]  <= i_row_address;
                        trcd_q[i_bank_address] <= TMR_W'(T_RCD);
                    end
                    CMD_RD: tccd_q <= TMR_W'(T_CCD);
                    CMD_WR: begin
                        tccd_q                <= TMR_W'(T_CCD);
                        twr_q[i_bank_address] <= TMR_W'(TWR_LOAD);
                    end
                    CMD_PRE: begin
                        bank_q[i_bank_address] <= BANK_CLOSED;
                        trp_q[i_bank_address]  <= TMR_W'(T_RP);
                    end
                    CMD_REF: rfc_q <= TMR_W'(T_RFC);
                    default: ;
                endcase
            end
        end
    end

    dq_burst_engine #(
        .DQ_BITS (DQ_BITS),
        .BL      (BL),
        .CL      (CL),
        .CWL     (CWL)
    ) u_dq_burst_engine (
        .clk               (clk),
        .rst               (rst),
        .i_rd_start        (cmd_accept && i_command == CMD_RD),
        .i_wr_start        (cmd_accept && i_command == CMD_WR),
        .i_query_wr        (i_command == CMD_WR),
        .i_wr_data         (i_full_write_data),
        .o_slot_busy       (slot_busy),
        .o_dq_out          (o_dq_out),
        .o_dq_oe           (o_dq_oe),
        .i_dq_in           (i_dq_in),
        .o_read_data_valid (o_read_data_valid),
        .o_full_read_data  (o_full_read_data)
    );

    assign o_cmd_accept     = cmd_accept;
    assign o_violation      = violation;
    assign o_violation_code = viol_code;

endmodule

// File: tb/tb_dram_cmd_responder.sv
// tb/tb_dram_cmd_responder.sv - directed self-checking bench for dram_cmd_responder
module tb_dram_cmd_responder;
    import command_definition_pkg::*;

    localparam int DQ_BITS = 16;
    localparam int W       = 8 * DQ_BITS;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_cmd_valid;
    bank_command_t   i_command;
    logic [2:0]      i_bank_address;
    logic [15:0]     i_row_address;
    logic [W-1:0]    i_full_write_data;
    logic            o_cmd_accept, o_violation, o_dq_oe, o_read_data_valid;
    viol_code_t      o_violation_code;
    logic [15:0]     o_dq_out, i_dq_in;
    logic [W-1:0]    o_full_read_data;
    logic [7:0]      o_bank_open;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_n    = 0;
    int dq_base  = 0;

    always #5 clk = ~clk;

    dram_cmd_responder dut (
        .clk               (clk),
        .rst               (rst),
        .i_cmd_valid       (i_cmd_valid),
        .i_command         (i_command),
        .i_bank_address    (i_bank_address),
        .i_row_address     (i_row_address),
        .i_full_write_data (i_full_write_data),
        .o_cmd_accept      (o_cmd_accept),
        .o_violation       (o_violation),
        .o_violation_code  (o_violation_code),
        .o_dq_out          (o_dq_out),
        .o_dq_oe           (o_dq_oe),
        .i_dq_in           (i_dq_in),
        .o_read_data_valid (o_read_data_valid),
        .o_full_read_data  (o_full_read_data),
        .o_bank_open       (o_bank_open)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_n++;
        i_cmd_valid = 1'b0;
        i_command   = CMD_NOP;
        i_dq_in     = 16'(cyc_n - dq_base);
    endtask

    task automatic go(input int c);
        while (cyc_n < c) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
        cyc_n = 0;
        i_dq_in = 16'(0 - dq_base);
    endtask

    task automatic issue(input bank_command_t cmd, input int bank, input logic [W-1:0] data);
        i_cmd_valid       = 1'b1;
        i_command         = cmd;
        i_bank_address    = 3'(bank);
        i_row_address     = 16'h0012;
        i_full_write_data = data;
        #1;
    endtask

    task automatic expect_cmd(input string tag, input logic acc, input viol_code_t code);
        check(tag, W'({o_cmd_accept, o_violation, o_violation_code}),
              W'({acc, code != VIOL_NONE, code}));
    endtask

    function automatic logic [W-1:0] ramp(input int first);
        logic [W-1:0] v;
        for (int k = 0; k < 8; k++) v[k*16 +: 16] = 16'(first + k);
        return v;
    endfunction

    logic [W-1:0] wdata;
    logic         seen_oe, seen_valid;

    initial begin
        i_cmd_valid = 1'b0; i_command = CMD_NOP; i_bank_address = '0;
        i_row_address = '0; i_full_write_data = '0; i_dq_in = '0; rst = 1'b1;

        // read path, tRCD, tCCD, bus turnaround
        dq_base = 9;
        do_reset();
        check("rst_bank_open", W'(o_bank_open), '0);
        check("rst_dq_oe", W'(o_dq_oe), '0);
        check("rst_rd_valid", W'(o_read_data_valid), '0);
        check("rst_rd_data", o_full_read_data, '0);
        check("rst_accept_viol", W'({o_cmd_accept, o_violation}), '0);
        issue(CMD_ACT, 0, '0); expect_cmd("act_b0", 1'b1, VIOL_NONE);
        tick(); check("b0_open", W'(o_bank_open), W'(8'h01));
        go(2);  issue(CMD_RD, 0, '0); expect_cmd("rd_trcd", 1'b0, VIOL_TRCD);
        go(4);  issue(CMD_RD, 0, '0); expect_cmd("rd_ok", 1'b1, VIOL_NONE);
        go(16); check("rd_valid_early", W'(o_read_data_valid), '0);
        go(17); check("rd_valid", W'(o_read_data_valid), W'(1));
        check("rd_data", o_full_read_data, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
        go(18); check("rd_valid_pulse", W'(o_read_data_valid), '0);
        check("rd_data_held", o_full_read_data, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
        dq_base = 0;
        go(20); issue(CMD_RD, 0, '0); expect_cmd("rd_t", 1'b1, VIOL_NONE);
        go(27); issue(CMD_RD, 0, '0); expect_cmd("rd_t7_tccd", 1'b0, VIOL_TCCD);
        go(28); issue(CMD_RD, 0, '0); expect_cmd("rd_t8", 1'b1, VIOL_NONE);
        go(33); check("b2b_valid1", W'(o_read_data_valid), W'(1));
        check("b2b_data1", o_full_read_data, ramp(25));
        go(36); issue(CMD_RD, 0, '0); expect_cmd("rd_before_wr", 1'b1, VIOL_NONE);
        go(41); check("b2b_valid2", W'(o_read_data_valid), W'(1));
        check("b2b_data2", o_full_read_data, ramp(33));
        wdata = ramp(16'hB0);
        go(44); issue(CMD_WR, 0, wdata); expect_cmd("wr_bus", 1'b0, VIOL_BUS);
        go(45); issue(CMD_WR, 0, wdata); expect_cmd("wr_after_bus", 1'b1, VIOL_NONE);
        go(49); check("rd3_data", o_full_read_data, ramp(41));
        check("wr_beat0", W'({o_dq_oe, o_dq_out}), W'({1'b1, 16'hB0}));
        go(53); issue(CMD_RD, 0, '0); expect_cmd("rd_after_wr", 1'b1, VIOL_NONE);

        // write path and tWR / tRP
        do_reset();
        issue(CMD_ACT, 1, '0); expect_cmd("act_b1", 1'b1, VIOL_NONE);
        wdata = ramp(16'hA0);
        go(4);  issue(CMD_WR, 1, wdata); expect_cmd("wr_b1", 1'b1, VIOL_NONE);
        go(7);  check("wr_oe_early", W'(o_dq_oe), '0);
        for (int k = 0; k < 8; k++) begin
            go(8 + k);
            check($sformatf("wr_beat%0d", k), W'({o_dq_oe, o_dq_out}), W'({1'b1, 16'(16'hA0 + k)}));
        end
        go(16); check("wr_oe_late", W'({o_dq_oe, o_dq_out}), '0);
        go(20); issue(CMD_PRE, 1, '0); expect_cmd("pre_twr", 1'b0, VIOL_TWR);
        go(21); issue(CMD_PRE, 1, '0); expect_cmd("pre_ok", 1'b1, VIOL_NONE);
        go(22); check("b1_closed", W'(o_bank_open), '0);
        issue(CMD_PRE, 1, '0); expect_cmd("pre_closed", 1'b0, VIOL_BANK_CLOSED);
        go(23); issue(CMD_RD, 1, '0); expect_cmd("rd_closed", 1'b0, VIOL_BANK_CLOSED);
        go(24); issue(CMD_ACT, 1, '0); expect_cmd("act_trp", 1'b0, VIOL_TRP);
        go(25); issue(CMD_ACT, 1, '0); expect_cmd("act_trp_done", 1'b1, VIOL_NONE);

        // refresh
        do_reset();
        issue(CMD_ACT, 2, '0); expect_cmd("act_b2", 1'b1, VIOL_NONE);
        go(1);  issue(CMD_REF, 0, '0); expect_cmd("ref_open", 1'b0, VIOL_BANK_OPEN);
        go(2);  issue(CMD_REF, 0, '0); i_cmd_valid = 1'b0; #1;
        expect_cmd("ref_not_valid", 1'b0, VIOL_NONE);
        go(4);  issue(CMD_PRE, 2, '0); expect_cmd("pre_b2", 1'b1, VIOL_NONE);
        go(5);  issue(CMD_REF, 0, '0); expect_cmd("ref_trp", 1'b0, VIOL_TRP);
        go(8);  issue(CMD_REF, 0, '0); expect_cmd("ref_ok", 1'b1, VIOL_NONE);
        go(9);  issue(CMD_ACT, 0, '0); expect_cmd("act_busy_first", 1'b0, VIOL_BUSY_REF);
        go(39); issue(CMD_ACT, 2, '0); expect_cmd("act_busy_last", 1'b0, VIOL_BUSY_REF);
        go(40); issue(CMD_ACT, 2, '0); expect_cmd("act_after_ref", 1'b1, VIOL_NONE);

        // reset in the middle of a write burst with a read pending
        do_reset();
        issue(CMD_ACT, 0, '0); expect_cmd("e_act", 1'b1, VIOL_NONE);
        go(4);  issue(CMD_WR, 0, ramp(16'hC0)); expect_cmd("e_wr", 1'b1, VIOL_NONE);
        go(12); issue(CMD_RD, 0, '0); expect_cmd("e_rd", 1'b1, VIOL_NONE);
        go(14); check("e_mid_burst", W'({o_dq_oe, o_dq_out}), W'({1'b1, 16'hC6}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("e_oe_after_rst", W'(o_dq_oe), '0);
        check("e_banks_closed", W'(o_bank_open), '0);
        seen_oe = 1'b0; seen_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (o_dq_oe) seen_oe = 1'b1;
            if (o_read_data_valid) seen_valid = 1'b1;
        end
        check("e_no_oe", W'(seen_oe), '0);
        check("e_no_rd_valid", W'(seen_valid), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
